// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared types and width defaults for the SRAM arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_if.sv
// ============================================================================
// Module   : sram_arbiter_if
// Brief    : Fetch/data request ports and SRAM macro signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              sram_w_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    // Requester side together with the SRAM macro model.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
        input  sram_w_en, sram_addr, sram_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
        output sram_w_en, sram_addr, sram_wdata
    );

endinterface

`default_nettype wire

// File: rtl/sram_arb_pick.sv
// ============================================================================
// Module   : sram_arb_pick
// Brief    : Combinational winner select; SRAM_ARB_RR_EN enables round-robin,
//            otherwise the data port has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  wire logic   i_req,
    input  wire logic   d_req,
`ifdef SRAM_ARB_RR_EN
    input  wire owner_t rr_last,
`endif
    output logic        any_req,
    output owner_t      winner
);

    always_comb begin
        any_req = i_req | d_req;
        winner  = d_req ? OWN_D : OWN_I;
`ifdef SRAM_ARB_RR_EN
        // On a conflict the port not served last goes first.
        if (i_req && d_req) begin
            winner = (rr_last == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port (fetch/data) arbiter and access sequencer for a shared
//            single-port SRAM. Build option: SRAM_ARB_RR_EN (round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
)(
    input  wire logic     clk,
    input  wire logic     rst,
    sram_arbiter_if.slave bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_latch;
    logic              w_any_req;
    owner_t            w_winner;
    owner_t            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_i_done;
    logic              r_d_done;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_access;

`ifdef SRAM_ARB_RR_EN
    owner_t            r_rr_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= OWN_I;
        end else if (w_latch) begin
            r_rr_last <= w_winner;
        end
    end
`endif

    sram_arb_pick u_pick (
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
`ifdef SRAM_ARB_RR_EN
        .rr_last (r_rr_last),
`endif
        .any_req (w_any_req),
        .winner  (w_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = ACCESS;
                    w_latch      = 1'b1;
                end
            end
            ACCESS:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Reset during ACCESS aborts the cycle: no enable, no grant.
    assign w_access = (r_state == ACCESS) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= OWN_I;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_owner <= w_winner;
                if (w_winner == OWN_D) begin
                    r_addr  <= bus.d_addr;
                    r_we    <= bus.d_we;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_addr  <= bus.i_addr;
                    r_we    <= 1'b0;
                end
            end
            r_i_done <= (r_state == ACCESS) && (r_owner == OWN_I);
            r_d_done <= (r_state == ACCESS) && (r_owner == OWN_D);
            if ((r_state == ACCESS) && !r_we) begin
                if (r_owner == OWN_I) begin
                    r_i_rdata <= bus.sram_rdata;
                end else begin
                    r_d_rdata <= bus.sram_rdata;
                end
            end
        end
    end

    assign bus.i_gnt      = w_access && (r_owner == OWN_I);
    assign bus.d_gnt      = w_access && (r_owner == OWN_D);
    assign bus.i_done     = r_i_done;
    assign bus.d_done     = r_d_done;
    assign bus.i_rdata    = r_i_rdata;
    assign bus.d_rdata    = r_d_rdata;
    assign bus.sram_w_en  = w_access && r_we;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed self-checking bench for sram_arbiter with an SRAM model.
//            Conflict checks follow SRAM_ARB_RR_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    sram_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:65535];
    logic        pre_we   = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign bus.sram_rdata = mem[bus.sram_addr];

    always @(posedge clk) begin
        if (bus.sram_w_en) mem[bus.sram_addr] <= bus.sram_wdata;
        else if (pre_we)   mem[pre_addr]      <= pre_data;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus.i_gnt, bus.d_gnt, bus.i_done, bus.d_done, bus.sram_w_en};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset with SRAM preload
        pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 32'hDEADBEEF;
        tick();
        pre_addr = 16'h0030; pre_data = 32'h0BADF00D;
        tick();
        pre_we = 1'b0;
        chk("reset_outs",  {27'd0, outs()}, 32'd0);
        chk("reset_irdat", bus.i_rdata, 32'd0);
        chk("reset_drdat", bus.d_rdata, 32'd0);
        chk("reset_addr",  {16'd0, bus.sram_addr}, 32'd0);
        chk("reset_wdata", bus.sram_wdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset_outs", {27'd0, outs()}, 32'd0);

        // Single data read
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
        tick();
        chk("rd_gnt",   {27'd0, outs()}, 32'b01000);
        chk("rd_addr",  {16'd0, bus.sram_addr}, 32'h0010);
        bus.d_req = 1'b0;
        tick();
        chk("rd_done",  {27'd0, outs()}, 32'b00010);
        chk("rd_rdata", bus.d_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_after", {27'd0, outs()}, 32'd0);

        // Data write followed by fetch of the same word
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 32'h12345678;
        tick();
        chk("wr_gnt",   {27'd0, outs()}, 32'b01001);
        chk("wr_wdata", bus.sram_wdata, 32'h12345678);
        chk("wr_addr",  {16'd0, bus.sram_addr}, 32'h0020);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        chk("wr_done",  {27'd0, outs()}, 32'b00010);
        chk("wr_mem",   mem[16'h0020], 32'h12345678);
        chk("wr_rdata_kept", bus.d_rdata, 32'hDEADBEEF);
        bus.i_req = 1'b1; bus.i_addr = 16'h0020;
        tick();
        chk("if_gnt",   {27'd0, outs()}, 32'b10000);
        bus.i_req = 1'b0;
        tick();
        chk("if_done",  {27'd0, outs()}, 32'b00100);
        chk("if_rdata", bus.i_rdata, 32'h12345678);

        // Idle hold
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_outs", {27'd0, outs()}, 32'd0);
        end
        chk("idle_irdat", bus.i_rdata, 32'h12345678);
        chk("idle_drdat", bus.d_rdata, 32'hDEADBEEF);

`ifdef SRAM_ARB_RR_EN
        // Both ports held: grants alternate starting with data
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", {30'd0, bus.i_gnt, bus.d_gnt}, (k % 2 == 0) ? 32'b01 : 32'b10);
            if (k == 3) begin
                bus.i_req = 1'b0; bus.d_req = 1'b0;
            end
            tick();
        end
        chk("rr_irdat", bus.i_rdata, 32'hDEADBEEF);
        chk("rr_drdat", bus.d_rdata, 32'h12345678);
        tick();
`else
        // Conflict with fixed priority: data first, fetch two cycles later
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
        tick();
        chk("fp_dgnt",  {30'd0, bus.i_gnt, bus.d_gnt}, 32'b01);
        bus.d_req = 1'b0;
        tick();
        chk("fp_ddone", {27'd0, outs()}, 32'b00010);
        chk("fp_drdat", bus.d_rdata, 32'h12345678);
        tick();
        chk("fp_ignt",  {30'd0, bus.i_gnt, bus.d_gnt}, 32'b10);
        chk("fp_iaddr", {16'd0, bus.sram_addr}, 32'h0010);
        bus.i_req = 1'b0;
        tick();
        chk("fp_idone", {27'd0, outs()}, 32'b00100);
        chk("fp_irdat", bus.i_rdata, 32'hDEADBEEF);
        tick();
`endif

        // Reset during the ACCESS cycle of a write
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0030; bus.d_wdata = 32'hAAAA5555;
        tick();
        chk("rw_gnt",   {27'd0, outs()}, 32'b01001);
        rst = 1'b1;
        #1;
        chk("rw_abort", {27'd0, outs()}, 32'd0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        chk("rw_mem",   mem[16'h0030], 32'h0BADF00D);
        chk("rw_outs",  {27'd0, outs()}, 32'd0);
        chk("rw_irdat", bus.i_rdata, 32'd0);
        chk("rw_drdat", bus.d_rdata, 32'd0);
        chk("rw_addr",  {16'd0, bus.sram_addr}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rw_nodone", {27'd0, outs()}, 32'd0);

        // FSM back in IDLE: a fresh read is served with normal latency
        bus.d_req = 1'b1; bus.d_addr = 16'h0030;
        tick();
        chk("rw2_gnt",  {27'd0, outs()}, 32'b01000);
        bus.d_req = 1'b0;
        tick();
        chk("rw2_done", {27'd0, outs()}, 32'b00010);
        chk("rw2_rdat", bus.d_rdata, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the shared single-port 64K×32 SRAM. It serves an instruction-fetch port (i_) and a data load/store port (d_). It accepts one request at a time, drives the SRAM's write enable, address and write data from registered copies, and returns registered read data with a one-cycle done pulse. It sits between the core's fetch/LSU stages and the SRAM macro.

## Interface
- ADDR_W, 16, SRAM word-address width
- DATA_W, 32, data word width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch request accepted (1-cycle pulse)
- i_done  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DATA_W  fetch read data, registered
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_done  out  1  data access complete (1-cycle pulse)
- d_rdata  out  DATA_W  data read data, registered
- sram_w_en  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM combinational read data

## Operation
- FSM states IDLE and ACCESS; reset → IDLE.
- IDLE: if any req=1, pick a winner and latch its addr, we (fetch: 0) and wdata into addr_q/we_q/wdata_q, record owner_q, then go to ACCESS. If no req, stay in IDLE.
- ACCESS: sram_addr=addr_q, sram_wdata=wdata_q, sram_w_en=we_q & ~rst; winner's gnt=1. At the closing edge, a read captures sram_rdata into the owner's rdata register and a write is committed by the SRAM. The owner's done is set for the next cycle, then the FSM returns to IDLE.
- Outside ACCESS: sram_w_en=0, and sram_addr/sram_wdata hold the last latched values.
- Writes: d_done pulses; d_rdata is unchanged.
- Requester rule: hold req/addr/we/wdata stable until gnt is seen, then drop req the next cycle. A req still high in IDLE is a new request.
- Default arbitration is fixed priority: d_ wins a conflict.
- Reset values: i_gnt, d_gnt, i_done, d_done, sram_w_en = 0; i_rdata, d_rdata, addr_q, wdata_q = 0; we_q = 0; owner_q = fetch; rr pointer = fetch.
- Reset asserted during ACCESS: sram_w_en is forced 0 in that cycle (the write is aborted), no done is generated, and the FSM goes to IDLE.

## Timing
- Request seen in IDLE cycle N → gnt and SRAM access in N+1 → done and rdata valid in N+2.
- N+2 is IDLE, so a new request is accepted in N+2.
- Peak throughput is one access per 2 cycles; a back-to-back request on the same port can be granted again in N+3.
- done of access k and gnt of access k+1 never overlap on the same port, but done on one port can coincide with acceptance of the other port's request.
- gnt and done are at most one-hot across ports per cycle.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - On a conflict, the port not served last wins; rr_last updates on every grant.
  - A sole requester is always served.
- SRAM_ARB_RR_EN undefined: fixed priority, d_ > i_; the rr pointer is not built.

## Structure
- Package sram_arb_pkg:
  - state enum {IDLE, ACCESS}
  - owner enum {OWN_I, OWN_D}
  - ADDR_W/DATA_W defaults
- Sub-module sram_arb_pick: combinational winner select from (i_req, d_req, rr_last), built with or without the macro. The FSM and datapath stay in sram_arbiter.

## Test plan
- Single read: preload mem[0x0010]=0xDEADBEEF; d_req, d_we=0, d_addr=0x0010 at N → d_gnt at N+1, d_done and d_rdata=0xDEADBEEF at N+2.
- Write then fetch: d write 0x12345678 to 0x0020, then i_req at 0x0020 → mem[0x0020]=0x12345678 after N+1, i_rdata=0x12345678 at i_done.
- Conflict, fixed priority: i_req and d_req held together from N → d_gnt at N+1, i_gnt at N+3.
- Conflict, SRAM_ARB_RR_EN: both held continuously for 4 grants → grants alternate D,I,D,I (rr_last reset = fetch).
- Reset mid-write: rst=1 during the ACCESS cycle of a write of 0xAAAA5555 to 0x0030 → sram_w_en=0, mem[0x0030] unchanged, no d_done, FSM in IDLE, all outputs 0.
- Idle hold: no requests for 10 cycles → sram_w_en=0, no gnt or done pulses, i_rdata/d_rdata unchanged.
